// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: FIFO-fed asynchronous serial transmitter (start, DATA_BITS data, optional parity via UART_PARITY_EN, one stop)
module uart_fifo_tx #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868,
  parameter int          DATA_BITS       = 8,
  parameter logic        PARITY_ODD      = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_empty_n,
  input  logic [7:0] i_data,
  output logic       o_rd,
  input  logic       i_cts_n,
  output logic       o_uart_tx,
  output logic       o_busy
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd4;
  logic [2:0]  state;
  logic [23:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        tx;
  logic        launch;
  logic        end_bit;
  logic [2:0]  after_data;
`ifdef UART_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
  logic par;
  // parity of the byte being loaded, held until its parity bit goes out
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) par <= 1'b0;
    else if (o_rd) par <= ^i_data[DATA_BITS-1:0] ^ PARITY_ODD;
  assign end_bit    = par;
  assign after_data = PARITY;
`else
  logic unused_par;
  assign unused_par = PARITY_ODD;
  assign end_bit    = 1'b1;
  assign after_data = STOP;
`endif
  // pop the FIFO from idle, or on the final stop cycle so frames run back-to-back
  assign launch    = (state == IDLE || (state == STOP && baud_cnt == '0)) && i_empty_n && !i_cts_n;
  assign o_rd      = i_rst_n && launch;
  assign o_busy    = state != IDLE;
  assign o_uart_tx = tx;
  // frame sequencer; the line register is updated together with the state so it is glitch-free
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else if (launch) begin
      state    <= START;
      baud_cnt <= CLOCKS_PER_BAUD - 24'd1;
      shreg    <= i_data;
      tx       <= 1'b0;
    end else if (state != IDLE) begin
      if (baud_cnt != '0) begin
        baud_cnt <= baud_cnt - 24'd1;
      end else begin
        baud_cnt <= CLOCKS_PER_BAUD - 24'd1;
        case (state)
          START: begin
            state   <= DATA;
            bit_cnt <= 3'(DATA_BITS - 1);
            tx      <= shreg[0];
          end
          DATA: begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt - 3'd1;
            state   <= (bit_cnt == '0) ? after_data : DATA;
            tx      <= (bit_cnt == '0) ? end_bit : shreg[1];
          end
          default: begin
            state <= (state == STOP) ? IDLE : STOP;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: directed checks of uart_fifo_tx at 4 clocks per bit fed from a small FIFO model
module tb_uart_fifo_tx;
  localparam int   CPB = 4;
  localparam logic PO  = 1'b0;
`ifdef UART_PARITY_EN
  localparam int FL = 11 * CPB;
`else
  localparam int FL = 10 * CPB;
`endif
  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_cts_n = 1'b0;
  logic       i_empty_n;
  logic [7:0] i_data;
  logic       o_rd, o_uart_tx, o_busy;
  logic [7:0] mem [16];
  logic [3:0] rp = '0;
  logic [3:0] wp = '0;
  int vecs = 0;
  int errs = 0;

  uart_fifo_tx #(.CLOCKS_PER_BAUD(24'(CPB)), .DATA_BITS(8), .PARITY_ODD(PO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_empty_n(i_empty_n), .i_data(i_data),
    .o_rd(o_rd), .i_cts_n(i_cts_n), .o_uart_tx(o_uart_tx), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;
  assign i_empty_n = rp != wp;
  assign i_data    = mem[rp];
  always @(posedge i_clk) if (o_rd) rp <= rp + 4'd1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 4'd1;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk); #1;
      chk({tag, "_tx"}, 8'(o_uart_tx), 8'd1);
      chk({tag, "_rd"}, 8'(o_rd), 8'd0);
      chk({tag, "_busy"}, 8'(o_busy), 8'd0);
    end
  endtask

  // called right after the pop edge; ends sampled in the last stop cycle
  task automatic frame(input logic [7:0] b, input string tag);
    logic exp;
    for (int i = 0; i < FL; i++) begin
      @(negedge i_clk); #1;
      exp = (i / CPB == 0) ? 1'b0 : (i / CPB <= 8) ? b[i / CPB - 1] : 1'b1;
`ifdef UART_PARITY_EN
      if (i / CPB == 9) exp = (^b) ^ PO;
`endif
      chk($sformatf("%s_tx%0d", tag, i), 8'(o_uart_tx), 8'(exp));
      chk($sformatf("%s_busy%0d", tag, i), 8'(o_busy), 8'd1);
      if (i < FL - 1) chk($sformatf("%s_rd%0d", tag, i), 8'(o_rd), 8'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_tx", 8'(o_uart_tx), 8'd1);
    chk("rst_busy", 8'(o_busy), 8'd0);
    chk("rst_rd", 8'(o_rd), 8'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle_cycles(100, "empty");
    push(8'hA5); #1;
    chk("a5_pop", 8'(o_rd), 8'd1);
    frame(8'hA5, "a5");
    chk("a5_end_rd", 8'(o_rd), 8'd0);
    idle_cycles(3, "a5_after");
    push(8'h00); push(8'hFF); push(8'h55); #1;
    chk("b2b_pop0", 8'(o_rd), 8'd1);
    frame(8'h00, "b00");
    chk("b2b_pop1", 8'(o_rd), 8'd1);
    frame(8'hFF, "bff");
    chk("b2b_pop2", 8'(o_rd), 8'd1);
    frame(8'h55, "b55");
    chk("b2b_end_rd", 8'(o_rd), 8'd0);
    idle_cycles(3, "b2b_after");
    i_cts_n = 1'b1;
    push(8'h3C); push(8'h81);
    idle_cycles(10, "cts_hold");
    i_cts_n = 1'b0; #1;
    chk("cts_release_pop", 8'(o_rd), 8'd1);
    @(posedge i_clk); #1;
    i_cts_n = 1'b1;
    frame(8'h3C, "c3c");
    chk("cts_mid_end_rd", 8'(o_rd), 8'd0);
    idle_cycles(8, "cts_wait");
    i_cts_n = 1'b0; #1;
    chk("cts_second_pop", 8'(o_rd), 8'd1);
    frame(8'h81, "c81");
    chk("c81_end_rd", 8'(o_rd), 8'd0);
    idle_cycles(3, "c81_after");
    push(8'hF0); #1;
    chk("rst_mid_pop", 8'(o_rd), 8'd1);
    repeat (18) @(negedge i_clk);
    #1;
    chk("rst_mid_bit3_tx", 8'(o_uart_tx), 8'd0);
    chk("rst_mid_bit3_busy", 8'(o_busy), 8'd1);
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_mid_async_tx", 8'(o_uart_tx), 8'd1);
    chk("rst_mid_async_busy", 8'(o_busy), 8'd0);
    chk("rst_mid_async_rd", 8'(o_rd), 8'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle_cycles(20, "post_rst");
`ifdef UART_PARITY_EN
    push(8'h07); #1;
    chk("par_pop", 8'(o_rd), 8'd1);
    frame(8'h07, "p07");
    chk("p07_end_rd", 8'(o_rd), 8'd0);
    idle_cycles(3, "p07_after");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
